cdb_arbiter: RTL and testbench

//  Shares a single common data bus (CDB) between two result producers: the ALU
//  (fed by the reservation station) and the load/store buffer.
//  - Each producer pushes (rob_id, result) into its own small FIFO.
//  - A round-robin arbiter broadcasts one result per cycle on a registered CDB.
//  - Consumers of the CDB: RS wakeup, LSB wakeup and ROB writeback.

---
 rtl/cdb_arbiter_pkg.sv | 30 +++
 rtl/cdb_arbiter_if.sv | 40 ++++
 rtl/cdb_fifo.sv | 56 +++++
 rtl/cdb_arbiter.sv | 121 ++++++++++++
 tb/tb_cdb_arbiter.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/cdb_arbiter_pkg.sv
// Shared types and constants for the CDB arbiter slice.
// Related build option: CDB_ARBITER_BYPASS_EN (see cdb_arbiter.sv).
package cdb_arbiter_pkg;

  localparam int ROB_ID_WIDTH = 4;
  localparam int DATA_WIDTH   = 32;

  typedef logic [ROB_ID_WIDTH-1:0] rob_id_t;
  typedef logic [DATA_WIDTH-1:0]   data_t;

  localparam rob_id_t ZERO_ROB  = '0;
  localparam data_t   ZERO_WORD = '0;
  localparam logic    TRUE      = 1'b1;
  localparam logic    FALSE     = 1'b0;

  typedef enum logic {
    CDB_SRC_ALU = 1'b0,
    CDB_SRC_LSB = 1'b1
  } cdb_src_t;

  typedef struct packed {
    rob_id_t rob_id;
    data_t   result;
  } cdb_entry_t;

  function automatic cdb_src_t other_src(cdb_src_t src);
    return (src == CDB_SRC_ALU) ? CDB_SRC_LSB : CDB_SRC_ALU;
  endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Producer-side and CDB-side signals of the arbiter, plus FIFO occupancy for observation.
interface cdb_arbiter_if
  import cdb_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
);
  logic     alu_valid;
  rob_id_t  alu_rob_id;
  data_t    alu_result;
  logic     alu_ready;

  logic     lsb_valid;
  rob_id_t  lsb_rob_id;
  data_t    lsb_result;
  logic     lsb_ready;

  logic     cdb_valid;
  rob_id_t  cdb_rob_id;
  data_t    cdb_result;
  cdb_src_t cdb_src;

  logic [$clog2(FIFO_DEPTH):0] alu_count;
  logic [$clog2(FIFO_DEPTH):0] lsb_count;

  modport slave (
    input  alu_valid, alu_rob_id, alu_result,
    input  lsb_valid, lsb_rob_id, lsb_result,
    output alu_ready, lsb_ready,
    output cdb_valid, cdb_rob_id, cdb_result, cdb_src,
    output alu_count, lsb_count
  );

  modport master (
    output alu_valid, alu_rob_id, alu_result,
    output lsb_valid, lsb_rob_id, lsb_result,
    input  alu_ready, lsb_ready,
    input  cdb_valid, cdb_rob_id, cdb_result, cdb_src,
    input  alu_count, lsb_count
  );
endinterface

// File: rtl/cdb_fifo.sv
// Small result FIFO with a combinational head; clears on rst or flush, freezes while rdy is low.
module cdb_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 36
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     rdy,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_reg == FULL_COUNT);
  assign empty   = (count_reg == '0);
  assign do_push = rdy && push && !full;
  assign do_pop  = rdy && pop && !empty;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + (AW+1)'(1);
        2'b01:   count_reg <= count_reg - (AW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Storage carries no reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= push_data;
  end

  assign head  = mem[rd_ptr_reg];
  assign count = count_reg;
endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin sharing of one registered CDB between the ALU and LSB result FIFOs.
// Build option CDB_ARBITER_BYPASS_EN: an empty FIFO's live input may go straight onto the CDB.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input logic          clk,
  input logic          rst,
  input logic          rdy,
  input logic          flush,
  cdb_arbiter_if.slave bus
);
  localparam int NUM_SRC = 2;
  localparam int COUNT_W = $clog2(FIFO_DEPTH) + 1;

  logic               in_valid [NUM_SRC];
  cdb_entry_t         in_entry [NUM_SRC];
  logic               push     [NUM_SRC];
  logic               pop      [NUM_SRC];
  logic               full     [NUM_SRC];
  logic               empty    [NUM_SRC];
  logic               req      [NUM_SRC];
  logic               granted  [NUM_SRC];
  cdb_entry_t         head     [NUM_SRC];
  cdb_entry_t         cand     [NUM_SRC];
  logic [COUNT_W-1:0] count    [NUM_SRC];

  cdb_src_t   rr_ptr_reg, rr_ptr_next;
  logic       grant_any;
  cdb_src_t   grant_src;
  cdb_entry_t grant_entry;
  logic       cdb_valid_reg;
  cdb_entry_t cdb_entry_reg;
  cdb_src_t   cdb_src_reg;

  // Index 0 is the ALU, index 1 the LSB, matching the cdb_src encoding.
  assign in_valid[0] = bus.alu_valid;
  assign in_entry[0] = {bus.alu_rob_id, bus.alu_result};
  assign in_valid[1] = bus.lsb_valid;
  assign in_entry[1] = {bus.lsb_rob_id, bus.lsb_result};

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
      cdb_fifo #(
        .DEPTH(FIFO_DEPTH),
        .WIDTH($bits(cdb_entry_t))
      ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .rdy       (rdy),
        .push      (push[gi]),
        .push_data (in_entry[gi]),
        .pop       (pop[gi]),
        .head      (head[gi]),
        .count     (count[gi]),
        .full      (full[gi]),
        .empty     (empty[gi])
      );
`ifdef CDB_ARBITER_BYPASS_EN
      logic bypass;
      assign bypass   = granted[gi] && empty[gi];
      assign req[gi]  = !empty[gi] || in_valid[gi];
      assign push[gi] = in_valid[gi] && !full[gi] && !bypass;
      assign cand[gi] = bypass ? in_entry[gi] : head[gi];
`else
      assign req[gi]  = !empty[gi];
      assign push[gi] = in_valid[gi] && !full[gi];
      assign cand[gi] = head[gi];
`endif
      assign pop[gi] = granted[gi] && !empty[gi];
    end
  endgenerate

  always_comb begin
    granted[0] = 1'b0;
    granted[1] = 1'b0;
    if (req[0] && req[1]) begin
      granted[0] = (rr_ptr_reg == CDB_SRC_ALU);
      granted[1] = (rr_ptr_reg == CDB_SRC_LSB);
    end else begin
      granted[0] = req[0];
      granted[1] = req[1];
    end
  end

  assign grant_any   = req[0] || req[1];
  assign grant_src   = granted[1] ? CDB_SRC_LSB : CDB_SRC_ALU;
  assign grant_entry = granted[1] ? cand[1] : cand[0];
  assign rr_ptr_next = grant_any ? other_src(grant_src) : rr_ptr_reg;

  // Tag and value hold across idle cycles; only the valid bit drops.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rr_ptr_reg    <= CDB_SRC_ALU;
      cdb_valid_reg <= FALSE;
      cdb_entry_reg <= {ZERO_ROB, ZERO_WORD};
      cdb_src_reg   <= CDB_SRC_ALU;
    end else if (rdy) begin
      rr_ptr_reg <= rr_ptr_next;
      if (grant_any) begin
        cdb_valid_reg <= TRUE;
        cdb_entry_reg <= grant_entry;
        cdb_src_reg   <= grant_src;
      end else begin
        cdb_valid_reg <= FALSE;
      end
    end
  end

  assign bus.alu_ready  = !full[0];
  assign bus.lsb_ready  = !full[1];
  assign bus.cdb_valid  = cdb_valid_reg;
  assign bus.cdb_rob_id = cdb_entry_reg.rob_id;
  assign bus.cdb_result = cdb_entry_reg.result;
  assign bus.cdb_src    = cdb_src_reg;
  assign bus.alu_count  = count[0];
  assign bus.lsb_count  = count[1];
endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios plus random traffic against a queue model.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rdy = 1'b1;
  logic flush = 1'b0;

  cdb_arbiter_if #(.FIFO_DEPTH(DEPTH)) bus ();

  cdb_arbiter #(.FIFO_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .rdy   (rdy),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Reference model: two queues of {tag, value}, a round-robin favourite and the CDB contents.
  logic [35:0] q_a[$];
  logic [35:0] q_l[$];
  bit          m_rr = 0;
  logic        m_valid = 0;
  logic [3:0]  m_id = 0;
  logic [31:0] m_res = 0;
  logic        m_src = 0;
  int          seen[$];

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit acc_a, acc_l, req_a, req_l, g_a, g_l;
    bit by_a, by_l;
    logic [35:0] e;
    by_a = 0;
    by_l = 0;
    e = '0;
    if (rst || flush) begin
      q_a.delete();
      q_l.delete();
      m_rr = 0;
      m_valid = 0;
      m_id = 0;
      m_res = 0;
      m_src = 0;
      return;
    end
    if (!rdy) return;
    acc_a = bus.alu_valid && (q_a.size() < DEPTH);
    acc_l = bus.lsb_valid && (q_l.size() < DEPTH);
`ifdef CDB_ARBITER_BYPASS_EN
    req_a = (q_a.size() != 0) || bus.alu_valid;
    req_l = (q_l.size() != 0) || bus.lsb_valid;
`else
    req_a = (q_a.size() != 0);
    req_l = (q_l.size() != 0);
`endif
    if (req_a && req_l) begin
      g_a = (m_rr == 0);
      g_l = !g_a;
    end else begin
      g_a = req_a;
      g_l = req_l;
    end
    if (g_a) begin
      if (q_a.size() != 0) e = q_a.pop_front();
      else begin
        e = {bus.alu_rob_id, bus.alu_result};
        by_a = 1;
      end
      m_src = 0;
      m_rr = 1;
    end
    if (g_l) begin
      if (q_l.size() != 0) e = q_l.pop_front();
      else begin
        e = {bus.lsb_rob_id, bus.lsb_result};
        by_l = 1;
      end
      m_src = 1;
      m_rr = 0;
    end
    if (g_a || g_l) begin
      m_valid = 1;
      m_id = e[35:32];
      m_res = e[31:0];
    end else begin
      m_valid = 0;
    end
    if (acc_a && !by_a) q_a.push_back({bus.alu_rob_id, bus.alu_result});
    if (acc_l && !by_l) q_l.push_back({bus.lsb_rob_id, bus.lsb_result});
  endtask

  task automatic check_all();
    chk("cdb_valid", bus.cdb_valid, m_valid);
    chk("cdb_rob_id", bus.cdb_rob_id, m_id);
    chk("cdb_result", bus.cdb_result, m_res);
    chk("cdb_src", bus.cdb_src, m_src);
    chk("alu_ready", bus.alu_ready, q_a.size() < DEPTH);
    chk("lsb_ready", bus.lsb_ready, q_l.size() < DEPTH);
    chk("alu_count", bus.alu_count, q_a.size());
    chk("lsb_count", bus.lsb_count, q_l.size());
    if (bus.cdb_valid === 1'b1) begin
      seen.push_back(int'(bus.cdb_rob_id));
      $display("cdb @%0t src=%0d tag=%0d value=%08h", $time, bus.cdb_src, bus.cdb_rob_id, bus.cdb_result);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic drive_alu(logic v, logic [3:0] id, logic [31:0] d);
    bus.alu_valid = v;
    bus.alu_rob_id = id;
    bus.alu_result = d;
  endtask

  task automatic drive_lsb(logic v, logic [3:0] id, logic [31:0] d);
    bus.lsb_valid = v;
    bus.lsb_rob_id = id;
    bus.lsb_result = d;
  endtask

  task automatic idle();
    drive_alu(1'b0, 4'd0, 32'd0);
    drive_lsb(1'b0, 4'd0, 32'd0);
  endtask

  initial begin
    int exp_order[8];
    exp_order = '{1, 9, 2, 10, 3, 11, 4, 12};
    idle();

    // Reset state
    rst = 1'b1;
    step();
    chk("rst_valid", bus.cdb_valid, 0);
    chk("rst_alu_ready", bus.alu_ready, 1);
    rst = 1'b0;

    // Single ALU push, tag 3 value 0x11
    drive_alu(1'b1, 4'd3, 32'h11);
    step();
`ifdef CDB_ARBITER_BYPASS_EN
    chk("t1_valid", bus.cdb_valid, 1);
    chk("t1_id", bus.cdb_rob_id, 3);
    chk("t1_res", bus.cdb_result, 32'h11);
    idle();
    step();
    chk("t1_drop", bus.cdb_valid, 0);
`else
    chk("t1_early", bus.cdb_valid, 0);
    idle();
    step();
    chk("t1_valid", bus.cdb_valid, 1);
    chk("t1_id", bus.cdb_rob_id, 3);
    chk("t1_res", bus.cdb_result, 32'h11);
    chk("t1_src", bus.cdb_src, 0);
    step();
    chk("t1_drop", bus.cdb_valid, 0);
`endif

    // Both producers every cycle from a fresh reset: strict alternation
    rst = 1'b1;
    step();
    rst = 1'b0;
    seen.delete();
    for (int i = 0; i < 4; i++) begin
      drive_alu(1'b1, 4'(1 + i), $urandom);
      drive_lsb(1'b1, 4'(9 + i), $urandom);
      step();
    end
    idle();
    for (int i = 0; i < 6; i++) step();
    chk("t2_count", seen.size(), 8);
    for (int i = 0; i < 8; i++) begin
      if (i < seen.size()) chk("t2_order", seen[i], exp_order[i]);
    end

    // Saturate both FIFOs so the full boundary is exercised
    for (int i = 0; i < 12; i++) begin
      drive_alu(1'b1, 4'($urandom_range(1, 15)), $urandom);
      drive_lsb(1'b1, 4'($urandom_range(1, 15)), $urandom);
      step();
    end
    chk("sat_lsb_full", bus.lsb_ready, 0);

    // rdy low for 3 cycles: everything frozen
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) step();
    rdy = 1'b1;
    idle();
    step();
    step();

    // Flush while entries are queued and the CDB is valid
    drive_alu(1'b1, 4'd5, $urandom);
    drive_lsb(1'b1, 4'd6, $urandom);
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    idle();
    chk("fl_valid", bus.cdb_valid, 0);
    chk("fl_alu_ready", bus.alu_ready, 1);
    chk("fl_lsb_ready", bus.lsb_ready, 1);
    step();
    chk("fl_no_stale", bus.cdb_valid, 0);

    // Reset during a stream, with a push in the same cycle
    for (int i = 0; i < 3; i++) begin
      drive_alu(1'b1, 4'($urandom_range(1, 15)), $urandom);
      drive_lsb(1'b1, 4'($urandom_range(1, 15)), $urandom);
      step();
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    idle();
    chk("rs_alu_count", bus.alu_count, 0);
    step();
    chk("rs_discard", bus.cdb_valid, 0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      drive_alu($urandom_range(0, 99) < 60, 4'($urandom_range(1, 15)), $urandom);
      drive_lsb($urandom_range(0, 99) < 60, 4'($urandom_range(1, 15)), $urandom);
      rdy = ($urandom_range(0, 99) < 80);
      flush = ($urandom_range(0, 99) < 3);
      rst = ($urandom_range(0, 99) < 2);
      step();
    end
    rst = 1'b0;
    flush = 1'b0;
    rdy = 1'b1;
    idle();
    for (int i = 0; i < 10; i++) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
